// File: rtl/stall_ctrl_if.sv
// stall_ctrl_if: groups the decoder-side hazard inputs and the pipeline-control
// outputs of the stall controller. The pipeline side (or a bench) uses the
// master modport; the stall controller itself uses the slave modport.
interface stall_ctrl_if;
    logic [4:0]  D_rs;
    logic [4:0]  D_rt;
    logic [1:0]  D_tuse_rs;
    logic [1:0]  D_tuse_rt;
    logic        D_is_md;
    logic [4:0]  E_wa;
    logic [1:0]  E_tnew;
    logic [4:0]  M_wa;
    logic [1:0]  M_tnew;
    logic        E_md_start;
    logic        E_md_type;
    logic        F_WE;
    logic        D_WE;
    logic        E_clr;
    logic        md_busy;
    logic [3:0]  md_cnt;
    logic [15:0] stall_cnt;

    modport master (
        output D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_is_md,
               E_wa, E_tnew, M_wa, M_tnew, E_md_start, E_md_type,
        input  F_WE, D_WE, E_clr, md_busy, md_cnt, stall_cnt
    );

    modport slave (
        input  D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_is_md,
               E_wa, E_tnew, M_wa, M_tnew, E_md_start, E_md_type,
        output F_WE, D_WE, E_clr, md_busy, md_cnt, stall_cnt
    );
endinterface

// File: rtl/stall_ctrl.sv
// stall_ctrl: hazard and stall controller for the 5-stage pipeline.
// Decides stalls from a Tuse/Tnew comparison against the E and M stages and
// from a busy counter modelling the multi-cycle mult/div unit.
// Optional feature macro: STALL_STATS_EN enables the saturating stall counter
// on stall_cnt; without it stall_cnt is a constant zero.
module stall_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic         clk,
    input  logic         reset,
    stall_ctrl_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    state_t     state;
    state_t     state_next;
    logic [3:0] cnt_q;
    logic [3:0] cnt_next;
    logic       busy_q;
    logic       busy_next;

    logic       hazard_rs;
    logic       hazard_rt;
    logic       md_stall;
    logic       stall;

    // State, remaining-cycle count and busy flag register; reset returns to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt_q  <= 4'd0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_next;
            cnt_q  <= cnt_next;
            busy_q <= busy_next;
        end
    end

    // Mult/div busy sequencing: load on a start in IDLE, count down in BUSY,
    // and release the unit when the last busy cycle (count 1) ends.
    always_comb begin
        state_next = state;
        cnt_next   = cnt_q;
        busy_next  = busy_q;
        unique case (state)
            IDLE: begin
                if (bus.E_md_start) begin
                    state_next = BUSY;
                    cnt_next   = bus.E_md_type ? DIV_LOAD : MULT_LOAD;
                    busy_next  = 1'b1;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd1) begin
                    state_next = IDLE;
                    cnt_next   = 4'd0;
                    busy_next  = 1'b0;
                end else begin
                    cnt_next   = cnt_q - 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
                busy_next  = 1'b0;
            end
        endcase
    end

    // Stall decision: a source register hazards when a producer in E or M
    // will not have its value ready by the time D needs it; r0 never hazards.
    always_comb begin
        hazard_rs = (bus.D_rs != 5'd0) &&
                    (((bus.D_rs == bus.E_wa) && (bus.E_tnew > bus.D_tuse_rs)) ||
                     ((bus.D_rs == bus.M_wa) && (bus.M_tnew > bus.D_tuse_rs)));
        hazard_rt = (bus.D_rt != 5'd0) &&
                    (((bus.D_rt == bus.E_wa) && (bus.E_tnew > bus.D_tuse_rt)) ||
                     ((bus.D_rt == bus.M_wa) && (bus.M_tnew > bus.D_tuse_rt)));
        md_stall  = bus.D_is_md && (busy_q || bus.E_md_start);
        stall     = !reset && (hazard_rs || hazard_rt || md_stall);
    end

    assign bus.F_WE    = !stall;
    assign bus.D_WE    = !stall;
    assign bus.E_clr   = stall;
    assign bus.md_busy = busy_q;
    assign bus.md_cnt  = cnt_q;

`ifdef STALL_STATS_EN
    logic [15:0] stall_cnt_q;

    // Stall statistics: count stalled cycles, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 16'h0000;
        end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
`else
    assign bus.stall_cnt = 16'h0000;
`endif

endmodule
